// File: rtl/mem_port_arbiter.sv
// Shares one memory read port between fetch and load (round-robin, 1-cycle read latency), drains stores
// through an in-order write buffer; reads matching a buffered store wait until it has drained.
module mem_port_arbiter #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  input  logic [63:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [63:0] if_resp_data,
  input  logic        ld_req_valid,
  input  logic [63:0] ld_req_addr,
  output logic        ld_req_ready,
  output logic        ld_resp_valid,
  output logic [63:0] ld_resp_data,
  input  logic        st_req_valid,
  input  logic [63:0] st_req_addr,
  input  logic [63:0] st_req_data,
  output logic        st_req_ready,
  output logic        wbuf_empty,
  output logic [63:0] mem_raddr,
  input  logic [63:0] mem_rdata,
  output logic        mem_wen,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  logic [63:0]   wb_addr [WBUF_DEPTH];
  logic [63:0]   wb_data [WBUF_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          rr;
  logic          tag_vld, tag_ld;
  logic [63:0]   raddr_q;

  logic if_hit, ld_hit, if_elig, ld_elig;
  logic grant_if, grant_ld, has_room, push, pop;

  // An entry is occupied when its distance from head is below count.
  always_comb begin
    if_hit = 1'b0;
    ld_hit = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if ({1'b0, PW'(i) - head} < count) begin
        if (wb_addr[i] == if_req_addr) if_hit = 1'b1;
        if (wb_addr[i] == ld_req_addr) ld_hit = 1'b1;
      end
    end
  end

  assign if_elig  = if_req_valid & ~if_hit & ~rst;
  assign ld_elig  = ld_req_valid & ~ld_hit & ~rst;
  assign grant_if = if_elig & (~ld_elig | ~rr);
  assign grant_ld = ld_elig & (~if_elig | rr);

  assign if_req_ready = grant_if;
  assign ld_req_ready = grant_ld;

  always_comb begin
    mem_raddr = raddr_q;
    if (rst)           mem_raddr = '0;
    else if (grant_if) mem_raddr = if_req_addr;
    else if (grant_ld) mem_raddr = ld_req_addr;
  end

  assign if_resp_valid = tag_vld & ~tag_ld & ~rst;
  assign ld_resp_valid = tag_vld & tag_ld & ~rst;
  assign if_resp_data  = mem_rdata;
  assign ld_resp_data  = mem_rdata;

  assign has_room     = count < CW'(WBUF_DEPTH);
  assign push         = st_req_valid & has_room & ~rst;
  assign pop          = (count != '0) & ~rst;
  assign st_req_ready = rst | has_room;
  assign wbuf_empty   = rst | (count == '0);
  assign mem_wen      = pop;
  assign mem_waddr    = wb_addr[head];
  assign mem_wdata    = wb_data[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      rr      <= 1'b0;
      tag_vld <= 1'b0;
      tag_ld  <= 1'b0;
      raddr_q <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count   <= count + CW'(push) - CW'(pop);
      tag_vld <= grant_if | grant_ld;
      tag_ld  <= grant_ld;
      if (grant_if | grant_ld) rr <= grant_if;
      raddr_q <= mem_raddr;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[tail] <= st_req_addr;
      wb_data[tail] <= st_req_data;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model, per-cycle reference model compare, directed scenarios.
module tb_mem_port_arbiter;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        if_req_valid, ld_req_valid, st_req_valid;
  logic [63:0] if_req_addr, ld_req_addr, st_req_addr, st_req_data;
  logic        if_req_ready, ld_req_ready, st_req_ready;
  logic        if_resp_valid, ld_resp_valid, wbuf_empty, mem_wen;
  logic [63:0] if_resp_data, ld_resp_data, mem_raddr, mem_rdata, mem_waddr, mem_wdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.WBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_ready(ld_req_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .st_req_ready(st_req_ready), .wbuf_empty(wbuf_empty),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: read data the cycle after the address, write commits at the posedge.
  logic [63:0] mem [logic [63:0]];

  function automatic logic [63:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  always @(posedge clk) begin
    mem_rdata <= rd(mem_raddr);
    if (mem_wen) mem[mem_waddr] = mem_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: store queue, round-robin bit, pending read and last read address.
  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } st_t;

  st_t         q[$];
  bit          m_rr, m_pv, m_pld;
  logic [63:0] m_pd, m_raddr;

  initial begin
    bit hi, hl, ei, el, gi, gl;
    logic [63:0] er;
    int sz;
    m_rr = 0; m_pv = 0; m_pld = 0; m_pd = '0; m_raddr = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("m_rst_if_rdy", if_req_ready, 0);
        chk("m_rst_ld_rdy", ld_req_ready, 0);
        chk("m_rst_if_resp", if_resp_valid, 0);
        chk("m_rst_ld_resp", ld_resp_valid, 0);
        chk("m_rst_wen", mem_wen, 0);
        chk("m_rst_empty", wbuf_empty, 1);
        chk("m_rst_st_rdy", st_req_ready, 1);
        chk("m_rst_raddr", mem_raddr, 0);
        q.delete();
        m_rr = 0; m_pv = 0; m_pld = 0; m_raddr = '0;
      end else begin
        hi = 0; hl = 0;
        foreach (q[k]) begin
          if (q[k].a == if_req_addr) hi = 1;
          if (q[k].a == ld_req_addr) hl = 1;
        end
        ei = if_req_valid && !hi;
        el = ld_req_valid && !hl;
        gi = ei && (!el || !m_rr);
        gl = el && (!ei || m_rr);
        er = gi ? if_req_addr : (gl ? ld_req_addr : m_raddr);
        chk("m_if_rdy", if_req_ready, gi);
        chk("m_ld_rdy", ld_req_ready, gl);
        chk("m_raddr", mem_raddr, er);
        chk("m_if_resp", if_resp_valid, m_pv && !m_pld);
        chk("m_ld_resp", ld_resp_valid, m_pv && m_pld);
        if (m_pv && !m_pld) chk("m_if_data", if_resp_data, m_pd);
        if (m_pv && m_pld)  chk("m_ld_data", ld_resp_data, m_pd);
        chk("m_wen", mem_wen, q.size() != 0);
        if (q.size() != 0) begin
          chk("m_waddr", mem_waddr, q[0].a);
          chk("m_wdata", mem_wdata, q[0].d);
        end
        chk("m_empty", wbuf_empty, q.size() == 0);
        chk("m_st_rdy", st_req_ready, q.size() < DEPTH);
        m_pv  = gi || gl;
        m_pld = gl;
        m_pd  = rd(er);
        if (gi || gl) m_rr = gi;
        m_raddr = er;
        sz = q.size();
        if (sz > 0) void'(q.pop_front());
        if (st_req_valid && sz < DEPTH) q.push_back('{st_req_addr, st_req_data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_req_valid = 0; ld_req_valid = 0; st_req_valid = 0;
    if_req_addr = '0; ld_req_addr = '0; st_req_addr = '0; st_req_data = '0;
    mem[64'h100] = 64'hAA;
    mem[64'h200] = 64'h22;
    mem[64'h208] = 64'h99;
    mem[64'h300] = 64'h11;
    mem[64'h500] = 64'h5005;
    mem[64'h600] = 64'h6006;
    step(); step();
    @(negedge clk);
    chk("rst_empty", wbuf_empty, 1);
    chk("rst_st_rdy", st_req_ready, 1);
    chk("rst_wen", mem_wen, 0);
    chk("rst_raddr", mem_raddr, 0);

    // single fetch
    step(); rst = 0; if_req_valid = 1; if_req_addr = 64'h100;
    @(negedge clk);
    chk("fetch_rdy", if_req_ready, 1);
    chk("fetch_raddr", mem_raddr, 64'h100);
    step(); if_req_valid = 0;
    @(negedge clk);
    chk("fetch_resp_vld", if_resp_valid, 1);
    chk("fetch_resp_data", if_resp_data, 64'hAA);
    chk("fetch_ld_resp", ld_resp_valid, 0);

    // contention from rr=0
    step(); rst = 1;
    step(); rst = 0;
    if_req_valid = 1; if_req_addr = 64'h500;
    ld_req_valid = 1; ld_req_addr = 64'h600;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_if_rdy", if_req_ready, (i % 2) == 0);
      chk("cont_ld_rdy", ld_req_ready, (i % 2) == 1);
      if (i > 0) begin
        chk("cont_if_resp", if_resp_valid, (i % 2) == 1);
        chk("cont_ld_resp", ld_resp_valid, (i % 2) == 0);
        if (i % 2 == 1) chk("cont_if_data", if_resp_data, 64'h5005);
        else            chk("cont_ld_data", ld_resp_data, 64'h6006);
      end
      step();
    end
    if_req_valid = 0; ld_req_valid = 0;
    @(negedge clk);
    chk("cont_last_ld_resp", ld_resp_valid, 1);
    chk("cont_last_ld_data", ld_resp_data, 64'h6006);

    // back-to-back console stores
    for (int i = 0; i < 6; i++) begin
      step();
      st_req_valid = (i < 5);
      st_req_addr  = 64'hffff_ffff_ffff_ffff;
      st_req_data  = 64'h41 + 64'(i);
      @(negedge clk);
      if (i < 5) chk("fill_st_rdy", st_req_ready, 1);
      chk("fill_wen", mem_wen, i > 0);
      if (i > 0) chk("fill_wdata", mem_wdata, 64'h40 + 64'(i));
    end
    step();
    @(negedge clk);
    chk("fill_empty", wbuf_empty, 1);
    chk("fill_wen_off", mem_wen, 0);

    // read-after-write stall
    step(); st_req_valid = 1; st_req_addr = 64'h200; st_req_data = 64'h55;
    @(negedge clk);
    chk("raw_st_rdy", st_req_ready, 1);
    step(); st_req_valid = 0;
    ld_req_valid = 1; ld_req_addr = 64'h200;
    if_req_valid = 1; if_req_addr = 64'h208;
    @(negedge clk);
    chk("raw_ld_blocked", ld_req_ready, 0);
    chk("raw_if_rdy", if_req_ready, 1);
    chk("raw_wen", mem_wen, 1);
    chk("raw_waddr", mem_waddr, 64'h200);
    step(); if_req_valid = 0;
    @(negedge clk);
    chk("raw_ld_rdy", ld_req_ready, 1);
    chk("raw_if_data", if_resp_data, 64'h99);
    step(); ld_req_valid = 0;
    @(negedge clk);
    chk("raw_ld_resp", ld_resp_valid, 1);
    chk("raw_ld_data", ld_resp_data, 64'h55);

    // store and load to the same address in one cycle
    step(); st_req_valid = 1; st_req_addr = 64'h300; st_req_data = 64'h77;
    ld_req_valid = 1; ld_req_addr = 64'h300;
    @(negedge clk);
    chk("same_st_rdy", st_req_ready, 1);
    chk("same_ld_rdy", ld_req_ready, 1);
    step(); st_req_valid = 0; ld_req_valid = 0;
    @(negedge clk);
    chk("same_ld_data", ld_resp_data, 64'h11);
    chk("same_wdata", mem_wdata, 64'h77);
    step(); if_req_valid = 1; if_req_addr = 64'h300;
    @(negedge clk);
    chk("same_if_rdy", if_req_ready, 1);
    step(); if_req_valid = 0;
    @(negedge clk);
    chk("same_if_data", if_resp_data, 64'h77);

    // reset with stores buffered and a read in flight
    step(); st_req_valid = 1; st_req_addr = 64'h700; st_req_data = 64'hA1;
    step(); st_req_addr = 64'h708; st_req_data = 64'hA2;
    step(); st_req_addr = 64'h710; st_req_data = 64'hA3;
    if_req_valid = 1; if_req_addr = 64'h100;
    @(negedge clk);
    chk("mid_if_rdy", if_req_ready, 1);
    step(); rst = 1; st_req_valid = 0; if_req_valid = 0;
    @(negedge clk);
    chk("mid_rst_resp", if_resp_valid, 0);
    chk("mid_rst_wen", mem_wen, 0);
    step(); rst = 0;
    @(negedge clk);
    chk("mid_after_resp", if_resp_valid, 0);
    chk("mid_after_wen", mem_wen, 0);
    chk("mid_after_empty", wbuf_empty, 1);
    step(); if_req_valid = 1; if_req_addr = 64'h500;
    ld_req_valid = 1; ld_req_addr = 64'h600;
    @(negedge clk);
    chk("mid_rr_if", if_req_ready, 1);
    chk("mid_rr_ld", ld_req_ready, 0);
    step(); if_req_valid = 0; ld_req_valid = 0;
    @(negedge clk);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
